// File: rtl/zap_cp15_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : zap_cp15_responder_if
//  Description : Bundle of the CPU<->CP15 handshake and the single CPU
//                register-file port used by the responder. Signal names are
//                given from the responder's point of view (i_ = into the
//                responder, o_ = out of it).
//                  i_cp_dav       request valid (level, held until done)
//                  i_cp_word      coprocessor instruction word
//                  o_cp_done      request complete, held until dav drops
//                  o_reg_en       CPU register file access strobe
//                  o_reg_wr       1 = write CPU register, 0 = read
//                  o_reg_index    architectural register Rd
//                  o_reg_mode     CPU mode latched at accept
//                  o_reg_wr_data  data for CPU register write
//                  i_reg_rd_data  CPU register read data (1 cycle after read)
//                  i_cpsr_mode    current CPU mode
//                Modports: master = CPU side, slave = responder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zap_cp15_responder_if;
    logic        i_cp_dav;
    logic [31:0] i_cp_word;
    logic        o_cp_done;
    logic        o_reg_en;
    logic        o_reg_wr;
    logic [3:0]  o_reg_index;
    logic [4:0]  o_reg_mode;
    logic [31:0] o_reg_wr_data;
    logic [31:0] i_reg_rd_data;
    logic [4:0]  i_cpsr_mode;

    modport master (
        output i_cp_dav, i_cp_word, i_reg_rd_data, i_cpsr_mode,
        input  o_cp_done, o_reg_en, o_reg_wr, o_reg_index, o_reg_mode,
               o_reg_wr_data
    );

    modport slave (
        input  i_cp_dav, i_cp_word, i_reg_rd_data, i_cpsr_mode,
        output o_cp_done, o_reg_en, o_reg_wr, o_reg_index, o_reg_mode,
               o_reg_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/zap_cp15_responder.sv
`default_nettype none
// ============================================================================
//  Module      : zap_cp15_responder
//  Description : Coprocessor-side end of the ZAP CPU<->coprocessor handshake.
//                Executes MCR/MRC against a 16-entry CP15 register bank
//                (CRn=0 is the read-only ID register, CRn=1 the control
//                register) and holds done until the CPU drops dav.
//  Ports       : i_clk       core clock
//                i_reset_n   asynchronous active-low reset
//                cp          handshake + CPU register port (slave modport)
//                o_ctrl      live copy of the control register (bank[1])
//  Options     : `define ZAP_CP15_CYCLE_COUNTER_EN turns bank[15] into a
//                free-running 32-bit cycle counter (MCR loads it, MRC reads
//                the value present during the EXEC cycle). Undefined, bank[15]
//                is plain storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module zap_cp15_responder #(
    parameter logic [3:0]  CP_NUM   = 4'd15,
    parameter logic [31:0] ID_VALUE = 32'h4107_9000,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  wire logic             i_clk,
    input  wire logic             i_reset_n,
    zap_cp15_responder_if.slave   cp,
    output logic [31:0]           o_ctrl
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t      r_state_q,   w_state_d;
    logic [3:0]  r_crn_q,     w_crn_d;
    logic [3:0]  r_rd_q,      w_rd_d;
    logic        r_mrc_q,     w_mrc_d;
    logic [4:0]  r_mode_q,    w_mode_d;
    logic [31:0] r_rdata_q,   w_rdata_d;
    logic        r_done_q,    w_done_d;
    logic        r_reg_en_q,  w_reg_en_d;
    logic        r_reg_wr_q,  w_reg_wr_d;
    logic [31:0] r_wr_data_q, w_wr_data_d;
    logic [31:0] r_bank_q [1:15];
    logic [31:0] w_bank_d [1:15];

    // ------------------------------------------------------------------
    // Instruction decode of the incoming word (only used at accept)
    // ------------------------------------------------------------------
    logic        w_is_cprt;
    logic        w_is_mcr;
    logic        w_is_mrc;
    logic [3:0]  w_acc_crn;
    logic [3:0]  w_acc_rd;
    logic [31:0] w_acc_rd_val;
    logic        w_unused_word;

    assign w_is_cprt = (cp.i_cp_word[27:24] == 4'b1110) && cp.i_cp_word[4]
                    && (cp.i_cp_word[11:8] == CP_NUM);
    assign w_is_mcr  = w_is_cprt && !cp.i_cp_word[20];
    assign w_is_mrc  = w_is_cprt &&  cp.i_cp_word[20];
    assign w_acc_crn = cp.i_cp_word[19:16];
    assign w_acc_rd  = cp.i_cp_word[15:12];

    // Condition, opcode and CRm fields play no part in this responder.
    assign w_unused_word = ^{cp.i_cp_word[31:28], cp.i_cp_word[23:21],
                             cp.i_cp_word[7:5], cp.i_cp_word[3:0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_crn_d     = r_crn_q;
        w_rd_d      = r_rd_q;
        w_mrc_d     = r_mrc_q;
        w_mode_d    = r_mode_q;
        w_rdata_d   = r_rdata_q;
        w_done_d    = r_done_q;
        w_reg_en_d  = r_reg_en_q;
        w_reg_wr_d  = r_reg_wr_q;
        w_wr_data_d = r_wr_data_q;
        w_bank_d    = r_bank_q;

`ifdef ZAP_CP15_CYCLE_COUNTER_EN
        w_bank_d[15] = r_bank_q[15] + 32'd1;
`endif

        // MRC data is registered at accept so it is stable throughout EXEC.
        w_acc_rd_val = ID_VALUE;
        if (w_acc_crn != 4'd0) begin
            w_acc_rd_val = r_bank_q[w_acc_crn];
        end
`ifdef ZAP_CP15_CYCLE_COUNTER_EN
        // The counter advances on the accept edge, so the value present in
        // the EXEC cycle is one beyond the current one.
        if (w_acc_crn == 4'd15) begin
            w_acc_rd_val = r_bank_q[15] + 32'd1;
        end
`endif

        case (r_state_q)
            S_IDLE: begin
                if (cp.i_cp_dav) begin
                    w_crn_d  = w_acc_crn;
                    w_rd_d   = w_acc_rd;
                    w_mrc_d  = w_is_mrc;
                    w_mode_d = cp.i_cpsr_mode;
                    if (w_is_mcr) begin
                        w_state_d  = S_RD_REQ;
                        w_reg_en_d = 1'b1;
                        w_reg_wr_d = 1'b0;
                    end else if (w_is_mrc) begin
                        // Writing PC from CP15 is not supported; Rd=15 is a no-op.
                        w_state_d   = S_EXEC;
                        w_reg_en_d  = (w_acc_rd != 4'd15);
                        w_reg_wr_d  = 1'b1;
                        w_wr_data_d = w_acc_rd_val;
                    end else begin
                        w_state_d = S_DONE;
                        w_done_d  = 1'b1;
                    end
                end
            end

            S_RD_REQ: begin
                w_reg_en_d = 1'b0;
                w_state_d  = cp.i_cp_dav ? S_RD_WAIT : S_IDLE;
            end

            S_RD_WAIT: begin
                if (cp.i_cp_dav) begin
                    w_rdata_d = cp.i_reg_rd_data;
                    w_state_d = S_EXEC;
                end else begin
                    w_state_d = S_IDLE;
                end
            end

            S_EXEC: begin
                // Commit cycle: completes even if dav has dropped meanwhile.
                if (!r_mrc_q && (r_crn_q != 4'd0)) begin
                    w_bank_d[r_crn_q] = r_rdata_q;
                end
                w_reg_en_d  = 1'b0;
                w_reg_wr_d  = 1'b0;
                w_wr_data_d = 32'd0;
                w_done_d    = 1'b1;
                w_state_d   = S_DONE;
            end

            S_DONE: begin
                if (!cp.i_cp_dav) begin
                    w_done_d  = 1'b0;
                    w_state_d = S_IDLE;
                end
            end

            default: begin
                w_state_d  = S_IDLE;
                w_done_d   = 1'b0;
                w_reg_en_d = 1'b0;
                w_reg_wr_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state_q   <= S_IDLE;
            r_crn_q     <= 4'd0;
            r_rd_q      <= 4'd0;
            r_mrc_q     <= 1'b0;
            r_mode_q    <= 5'd0;
            r_rdata_q   <= 32'd0;
            r_done_q    <= 1'b0;
            r_reg_en_q  <= 1'b0;
            r_reg_wr_q  <= 1'b0;
            r_wr_data_q <= 32'd0;
            for (int i = 1; i <= 15; i++) begin
                r_bank_q[i] <= (i == 1) ? CTRL_RST : 32'd0;
            end
        end else begin
            r_state_q   <= w_state_d;
            r_crn_q     <= w_crn_d;
            r_rd_q      <= w_rd_d;
            r_mrc_q     <= w_mrc_d;
            r_mode_q    <= w_mode_d;
            r_rdata_q   <= w_rdata_d;
            r_done_q    <= w_done_d;
            r_reg_en_q  <= w_reg_en_d;
            r_reg_wr_q  <= w_reg_wr_d;
            r_wr_data_q <= w_wr_data_d;
            r_bank_q    <= w_bank_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cp.o_cp_done     = r_done_q;
    assign cp.o_reg_en      = r_reg_en_q;
    assign cp.o_reg_wr      = r_reg_wr_q;
    assign cp.o_reg_index   = r_rd_q;
    assign cp.o_reg_mode    = r_mode_q;
    assign cp.o_reg_wr_data = r_wr_data_q;
    assign o_ctrl           = r_bank_q[1];

endmodule
`default_nettype wire

// File: tb/tb_zap_cp15_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_zap_cp15_responder
//  Description : Self-checking bench for zap_cp15_responder. Table of
//                MCR/MRC/NOP vectors plus hand sequences for hold, abort,
//                mid-operation reset and (optionally) the cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_cp15_responder;

    localparam logic [31:0] ID_VALUE = 32'h4107_9000;
    localparam logic [31:0] CTRL_RST = 32'h0000_0000;
    localparam logic [31:0] GARBAGE  = 32'hBAD0_BAD0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] data;
        logic [4:0]  mode;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [3:0]  idx;
        logic [31:0] wd;
        logic [31:0] ctrl;
    } vec_t;

    typedef struct {
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [3:0]  rd_idx;
        logic [3:0]  wr_idx;
        logic [31:0] wr_data;
        logic [4:0]  mode;
        logic        held;
        logic        done_after;
        logic [31:0] ctrl;
        int          done_cyc;
        int          wr_cyc;
    } obs_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ctrl;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          edge_cnt = 0;
    vec_t        sb_q[$];

    zap_cp15_responder_if bus();

    zap_cp15_responder #(
        .CP_NUM   (4'd15),
        .ID_VALUE (ID_VALUE),
        .CTRL_RST (CTRL_RST)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .cp        (bus),
        .o_ctrl    (ctrl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // MCR/MRC word with non-zero opc1/opc2/CRm, which must be ignored.
    function automatic logic [31:0] cprt(input logic l, input logic [3:0] cpn,
                                         input logic [3:0] crn, input logic [3:0] rd);
        return {4'hE, 4'b1110, 3'b001, l, crn, rd, cpn, 3'b010, 1'b1, 4'h3};
    endfunction

    function automatic logic [31:0] cdp(input logic [3:0] crn, input logic [3:0] rd);
        return {4'hE, 4'b1110, 3'b001, 1'b0, crn, rd, 4'd15, 3'b010, 1'b0, 4'h3};
    endfunction

    // Drives one request, models the CPU register file read latency, and
    // records what the responder did. hold = extra cycles dav stays high
    // after done is first seen.
    task automatic do_op(input logic [31:0] word, input logic [31:0] data,
                         input logic [4:0] mode, input int hold, output obs_t o);
        int pend;
        int cyc;
        o = '{lat: -1, n_rd: 0, n_wr: 0, rd_idx: 4'd0, wr_idx: 4'd0, wr_data: 32'd0,
              mode: 5'd0, held: 1'b1, done_after: 1'b0, ctrl: 32'd0,
              done_cyc: 0, wr_cyc: 0};
        pend = 0;
        cyc  = 0;
        @(negedge clk);
        bus.i_cp_word   = word;
        bus.i_cpsr_mode = mode;
        bus.i_cp_dav    = 1'b1;
        while (o.lat < 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            bus.i_cpsr_mode   = ~mode;
            bus.i_reg_rd_data = (pend != 0) ? data : GARBAGE;
            pend = 0;
            if (bus.o_reg_en && !bus.o_reg_wr) begin
                o.n_rd++; o.rd_idx = bus.o_reg_index; o.mode = bus.o_reg_mode; pend = 1;
            end
            if (bus.o_reg_en && bus.o_reg_wr) begin
                o.n_wr++; o.wr_idx = bus.o_reg_index; o.wr_data = bus.o_reg_wr_data;
                o.mode = bus.o_reg_mode; o.wr_cyc = edge_cnt;
            end
            if (bus.o_cp_done) begin
                o.lat = cyc; o.done_cyc = edge_cnt;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.o_reg_en && !bus.o_reg_wr) o.n_rd++;
            if (bus.o_reg_en &&  bus.o_reg_wr) o.n_wr++;
            if (!bus.o_cp_done) o.held = 1'b0;
        end
        bus.i_cp_dav = 1'b0;
        @(posedge clk); #1;
        o.done_after = bus.o_cp_done;
        o.ctrl       = ctrl;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int hold);
        obs_t o;
        vec_t e;
        sb_q.push_back(v);
        do_op(v.word, v.data, v.mode, hold, o);
        e = sb_q.pop_front();
        chk({tag, " latency"}, o.lat, e.lat);
        chk({tag, " rd strobes"}, o.n_rd, e.n_rd);
        chk({tag, " wr strobes"}, o.n_wr, e.n_wr);
        if (e.n_rd > 0) begin
            chk({tag, " rd index"}, {28'd0, o.rd_idx}, {28'd0, e.idx});
            chk({tag, " rd mode"}, {27'd0, o.mode}, {27'd0, e.mode});
        end
        if (e.n_wr > 0) begin
            chk({tag, " wr index"}, {28'd0, o.wr_idx}, {28'd0, e.idx});
            chk({tag, " wr data"}, o.wr_data, e.wd);
            chk({tag, " wr mode"}, {27'd0, o.mode}, {27'd0, e.mode});
        end
        if (hold > 0) chk({tag, " done held"}, {31'd0, o.held}, 32'd1);
        chk({tag, " done drop"}, {31'd0, o.done_after}, 32'd0);
        chk({tag, " ctrl"}, o.ctrl, e.ctrl);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        obs_t o1, o2;
        int   seen;

        bus.i_cp_dav      = 1'b0;
        bus.i_cp_word     = 32'd0;
        bus.i_reg_rd_data = 32'd0;
        bus.i_cpsr_mode   = 5'd0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset done",    {31'd0, bus.o_cp_done}, 32'd0);
        chk("reset reg_en",  {31'd0, bus.o_reg_en},  32'd0);
        chk("reset reg_wr",  {31'd0, bus.o_reg_wr},  32'd0);
        chk("reset index",   {28'd0, bus.o_reg_index}, 32'd0);
        chk("reset mode",    {27'd0, bus.o_reg_mode},  32'd0);
        chk("reset wr_data", bus.o_reg_wr_data, 32'd0);
        chk("reset ctrl",    ctrl, CTRL_RST);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        //         word                    data           mode   lat rd wr idx  wd            ctrl
        tbl.push_back('{cprt(0, 15, 1, 3),  32'h0000_0005, 5'h13, 4, 1, 0, 4'd3, 32'd0,        32'h5});
        tbl.push_back('{cprt(1, 15, 0, 2),  32'd0,         5'h10, 2, 0, 1, 4'd2, ID_VALUE,     32'h5});
        tbl.push_back('{cprt(1, 15, 1, 4),  32'd0,         5'h11, 2, 0, 1, 4'd4, 32'h5,        32'h5});
        tbl.push_back('{cprt(1, 15, 0, 15), 32'd0,         5'h13, 2, 0, 0, 4'd0, 32'd0,        32'h5});
        tbl.push_back('{cdp(1, 3),          32'h0000_0077, 5'h13, 1, 0, 0, 4'd0, 32'd0,        32'h5});
        tbl.push_back('{cprt(0, 15, 7, 1),  32'hDEAD_BEEF, 5'h12, 4, 1, 0, 4'd1, 32'd0,        32'h5});
        tbl.push_back('{cprt(1, 15, 7, 6),  32'd0,         5'h17, 2, 0, 1, 4'd6, 32'hDEAD_BEEF, 32'h5});
        tbl.push_back('{cprt(0, 15, 0, 8),  32'h1234_5678, 5'h13, 4, 1, 0, 4'd8, 32'd0,        32'h5});
        tbl.push_back('{cprt(1, 15, 0, 5),  32'd0,         5'h1B, 2, 0, 1, 4'd5, ID_VALUE,     32'h5});
        tbl.push_back('{cprt(0, 14, 7, 1),  32'h0000_0000, 5'h13, 1, 0, 0, 4'd0, 32'd0,        32'h5});
        tbl.push_back('{cprt(1, 15, 7, 0),  32'd0,         5'h1F, 2, 0, 1, 4'd0, 32'hDEAD_BEEF, 32'h5});
        tbl.push_back('{32'hED93_5F10,      32'h0000_0099, 5'h13, 1, 0, 0, 4'd0, 32'd0,        32'h5});
        tbl.push_back('{cprt(0, 15, 1, 2),  32'h0000_0007, 5'h10, 4, 1, 0, 4'd2, 32'd0,        32'h7});
        tbl.push_back('{cprt(1, 15, 1, 2),  32'd0,         5'h10, 2, 0, 1, 4'd2, 32'h7,        32'h7});
        tbl.push_back('{cdp(1, 2),          32'h0000_0003, 5'h13, 1, 0, 0, 4'd0, 32'd0,        32'h7});
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("v%0d", i), tbl[i], 0);
        end

        // ---------------- hold dav after done ----------------
        run_vec("hold mcr", '{cprt(0, 15, 2, 5), 32'h0000_0011, 5'h13, 4, 1, 0, 4'd5, 32'd0, 32'h7}, 5);
        run_vec("hold mrc", '{cprt(1, 15, 2, 6), 32'd0, 5'h13, 2, 0, 1, 4'd6, 32'h11, 32'h7}, 5);

        // ---------------- abort in RD_REQ (a=1) and RD_WAIT (a=2) ----------------
        for (int a = 1; a <= 2; a++) begin
            @(negedge clk);
            bus.i_cp_word   = cprt(0, 15, 2, 5);
            bus.i_cpsr_mode = 5'h13;
            bus.i_cp_dav    = 1'b1;
            for (int k = 0; k < a; k++) begin
                @(posedge clk); #1;
                bus.i_reg_rd_data = 32'h0000_0099;
            end
            bus.i_cp_dav = 1'b0;
            seen = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (bus.o_cp_done || bus.o_reg_en) seen++;
            end
            chk($sformatf("abort%0d activity", a), seen, 0);
            run_vec($sformatf("abort%0d check", a),
                    '{cprt(1, 15, 2, 5), 32'd0, 5'h13, 2, 0, 1, 4'd5, 32'h11, 32'h7}, 0);
        end

        // ---------------- reset mid-MCR (in RD_WAIT) ----------------
        @(negedge clk);
        bus.i_cp_word   = cprt(0, 15, 1, 3);
        bus.i_cpsr_mode = 5'h13;
        bus.i_cp_dav    = 1'b1;
        @(posedge clk); #1;
        chk("rstmid rd strobe", {31'd0, bus.o_reg_en}, 32'd1);
        @(posedge clk); #1;
        bus.i_reg_rd_data = 32'h0000_00F0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid done", {31'd0, bus.o_cp_done}, 32'd0);
        chk("rstmid ctrl", ctrl, CTRL_RST);
        bus.i_cp_dav = 1'b0;
        @(posedge clk); #1;
        chk("rstmid done next", {31'd0, bus.o_cp_done}, 32'd0);
        chk("rstmid reg_en next", {31'd0, bus.o_reg_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("rstmid crn1", '{cprt(1, 15, 1, 4), 32'd0, 5'h13, 2, 0, 1, 4'd4, CTRL_RST, CTRL_RST}, 0);
        run_vec("rstmid crn7", '{cprt(1, 15, 7, 4), 32'd0, 5'h13, 2, 0, 1, 4'd4, 32'd0, CTRL_RST}, 0);

        // ---------------- CRn=15 ----------------
`ifdef ZAP_CP15_CYCLE_COUNTER_EN
        do_op(cprt(0, 15, 15, 9), 32'hFFFF_FFFE, 5'h13, 0, o1);
        chk("ctr load latency", o1.lat, 4);
        do_op(cprt(1, 15, 15, 9), 32'd0, 5'h13, 0, o2);
        chk("ctr read latency", o2.lat, 2);
        chk("ctr read strobe", o2.n_wr, 1);
        // Counter holds FFFF_FFFE right after the loading edge, +1 per edge.
        v.wd = 32'hFFFF_FFFE + 32'(o2.wr_cyc - o1.done_cyc);
        chk("ctr wrapped value", o2.wr_data, v.wd);
`else
        run_vec("crn15 wr", '{cprt(0, 15, 15, 9), 32'hA5A5_5A5A, 5'h13, 4, 1, 0, 4'd9, 32'd0, CTRL_RST}, 0);
        repeat (4) @(posedge clk);
        run_vec("crn15 rd", '{cprt(1, 15, 15, 9), 32'd0, 5'h13, 2, 0, 1, 4'd9, 32'hA5A5_5A5A, CTRL_RST}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
